// File: rtl/encoding_slot_dm_packer.sv
// Multichannel time-multiplexed delta modulator with a P-channel spike word packer.
// Emits one 2P-bit bipolar spike word per channel group, tagged with group index and frame end.
module encoding_slot_dm_packer #(
    parameter  int unsigned CHANNELS = 128,
    parameter  int unsigned DW       = 8,
    parameter  int unsigned P        = 2,
    localparam int unsigned GW       = (CHANNELS / P > 1) ? $clog2(CHANNELS / P) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   data_in,
    input  logic [DW-1:0]   thr,
    input  logic            mode,
    output logic [2*P-1:0]  spike_word,
    output logic            valid_word,
    output logic [GW-1:0]   group_idx,
    output logic            active_group,
    output logic            frame_done
);

    localparam int unsigned GROUPS = CHANNELS / P;
    localparam int unsigned CW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int unsigned SW     = (P > 1) ? $clog2(P) : 1;
    localparam int unsigned BW     = 2 * P;

    logic signed [DW-1:0] r_ref [CHANNELS];
    logic [CW-1:0]        r_chan;
    logic [SW-1:0]        r_slot;
    logic [GW-1:0]        r_group;
    logic [BW-1:0]        r_buf;

    logic signed [DW-1:0] w_ref;
    logic [DW-1:0]        w_t;
    logic signed [DW:0]   w_t_s;
    logic signed [DW:0]   w_diff;
    logic                 w_pos;
    logic                 w_neg;
    logic [DW-1:0]        w_ref_nxt;
    logic [BW-1:0]        w_word;
    logic                 w_last_slot;
    logic                 w_last_group;

    // Delta decision and reference update for the channel presented this cycle
    always_comb begin
        w_ref     = r_ref[r_chan];
        w_t       = (thr == '0) ? DW'(1) : thr;
        w_t_s     = $signed({1'b0, w_t});
        w_diff    = $signed({data_in[DW-1], data_in}) - $signed({w_ref[DW-1], w_ref});
        w_pos     = (w_diff >= w_t_s);
        w_neg     = (w_diff <= -w_t_s);
        w_ref_nxt = w_ref;
        if (mode) begin
            if (w_pos || w_neg) begin
                w_ref_nxt = data_in;
            end
        end else if (w_pos) begin
            // pos/neg bound the step by data_in, so the DW-bit result cannot wrap
            w_ref_nxt = w_ref + w_t;
        end else if (w_neg) begin
            w_ref_nxt = w_ref - w_t;
        end
    end

    // Merge the current spike pair into the partial group word
    always_comb begin
        w_word = r_buf;
        for (int k = 0; k < int'(P); k++) begin
            if (r_slot == SW'(k)) begin
                w_word[2*k +: 2] = {w_pos, w_neg};
            end
        end
        w_last_slot  = (r_slot == SW'(P - 1));
        w_last_group = (r_group == GW'(GROUPS - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(CHANNELS); i++) begin
                r_ref[i] <= '0;
            end
            r_chan       <= '0;
            r_slot       <= '0;
            r_group      <= '0;
            r_buf        <= '0;
            spike_word   <= '0;
            group_idx    <= '0;
            valid_word   <= 1'b0;
            active_group <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            valid_word   <= 1'b0;
            active_group <= 1'b0;
            frame_done   <= 1'b0;
            if (en) begin
                r_ref[r_chan] <= w_ref_nxt;
                r_chan        <= (r_chan == CW'(CHANNELS - 1)) ? '0 : r_chan + CW'(1);
                if (w_last_slot) begin
                    spike_word   <= w_word;
                    group_idx    <= r_group;
                    valid_word   <= 1'b1;
                    active_group <= |w_word;
                    frame_done   <= w_last_group;
                    r_buf        <= '0;
                    r_slot       <= '0;
                    r_group      <= w_last_group ? '0 : r_group + GW'(1);
                end else begin
                    r_buf  <= w_word;
                    r_slot <= r_slot + SW'(1);
                end
            end
        end
    end

endmodule
